// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the calculator ALU sequencer.
package calc_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Width of an iteration counter that must reach w-1.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DATA_WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  // Two's-complement overflow of an addition, from the three sign bits.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Ripple-style DATA_WIDTH-bit adder with carry in/out; the only arithmetic unit of the sequencer.
module full_adder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  // Single wide addition; the carry out is the extra top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/adder_sequencer.sv
// Multi-cycle ALU controller: sequences one shared adder for ADD, SUB, PASS and
// shift-add MUL behind valid/ready handshakes, one transaction in flight.
module adder_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_c,
  output logic                  out_v,
  output logic                  out_z
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
  localparam int MSB = DATA_WIDTH - 1;

  seq_state_t            state_r, state_nxt_s;
  alu_op_t               op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;      // b_r doubles as the shifting multiplier
  logic [DATA_WIDTH-1:0] mcand_r, acc_r;
  logic                  ovf_r;
  logic [CW-1:0]         cnt_r;

  logic [DATA_WIDTH-1:0] add_a_s, add_b_s, sum_s;
  logic                  add_cin_s, cout_s;
  logic [DATA_WIDTH-1:0] acc_nxt_s;
  logic                  ovf_nxt_s, exec_c_s, exec_v_s;

  assign in_ready = (state_r == S_IDLE);

  full_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a   (add_a_s),
    .b   (add_b_s),
    .cin (add_cin_s),
    .sum (sum_s),
    .cout(cout_s)
  );

  // Steer the shared adder: operands in EXEC, accumulate step in MUL.
  always_comb begin
    add_a_s   = a_r;
    add_b_s   = b_r;
    add_cin_s = 1'b0;
    case (state_r)
      S_EXEC: begin
        case (op_r)
          OP_ADD: add_b_s = b_r;
          OP_SUB: begin
            add_b_s   = ~b_r;
            add_cin_s = 1'b1;
          end
          default: add_b_s = ZERO;
        endcase
      end
      S_MUL: begin
        add_a_s = acc_r;
        add_b_s = mcand_r;
      end
      default: add_cin_s = 1'b0;
    endcase
  end

  // One shift-add step and the EXEC flags derived from the adder output.
  always_comb begin
    if (b_r[0]) begin
      acc_nxt_s = sum_s;
    end else begin
      acc_nxt_s = acc_r;
    end
    // Overflow if a kept partial carries out, or a set mcand MSB will be shifted out
    // while multiplier bits remain.
    ovf_nxt_s = ovf_r | (b_r[0] & cout_s) | (mcand_r[MSB] & (|b_r[DATA_WIDTH-1:1]));
    if (op_r == OP_PASS) begin
      exec_c_s = 1'b0;
      exec_v_s = 1'b0;
    end else begin
      exec_c_s = cout_s;
      exec_v_s = add_overflow(add_a_s[MSB], add_b_s[MSB], sum_s[MSB]);
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt_s = (in_op == OP_MUL) ? S_MUL : S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: state_nxt_s = S_DONE;
      S_MUL: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latches, MUL working registers and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= OP_ADD;
      a_r        <= ZERO;
      b_r        <= ZERO;
      mcand_r    <= ZERO;
      acc_r      <= ZERO;
      ovf_r      <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      out_valid  <= 1'b0;
      out_result <= ZERO;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
      out_z      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            op_r    <= alu_op_t'(in_op);
            a_r     <= in_a;
            b_r     <= in_b;
            mcand_r <= in_a;
            acc_r   <= ZERO;
            ovf_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
          end
        end
        S_EXEC: begin
          out_result <= sum_s;
          out_c      <= exec_c_s;
          out_v      <= exec_v_s;
          out_z      <= (sum_s == ZERO);
          out_valid  <= 1'b1;
        end
        S_MUL: begin
          acc_r   <= acc_nxt_s;
          ovf_r   <= ovf_nxt_s;
          mcand_r <= {mcand_r[DATA_WIDTH-2:0], 1'b0};
          b_r     <= {1'b0, b_r[DATA_WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            out_result <= acc_nxt_s;
            out_c      <= 1'b0;
            out_v      <= ovf_nxt_s;
            out_z      <= (acc_nxt_s == ZERO);
            out_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer: vector table, scoreboard and multi-cycle corner sequences.
module tb_adder_sequencer;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b, out_result;
  logic         out_c, out_v, out_z;

  always #5 clk = ~clk;

  adder_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_c(out_c), .out_v(out_v), .out_z(out_z)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           lat;
  } vec_t;

  exp_t sb_q[$];
  exp_t got_m, exp_m;
  int   n_cmp = 0, n_err = 0, n_handoff = 0, n_push = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Independent reference: plain arithmetic on wide values.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    r = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0]; r.c = s[W];
        r.v = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r.res = a - b; r.c = (a >= b);
        r.v = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.res = p[W-1:0]; r.v = |p[2*W-1:W];
      end
      default: r.res = a;
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  task automatic push(input exp_t e);
    sb_q.push_back(e);
    n_push++;
  endtask

  // Scoreboard: every handshake on the output side is one popped comparison.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_handoff++;
      got_m = {out_result, out_c, out_v, out_z};
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL handoff: unexpected result %h c=%b v=%b z=%b, expected none", out_result, out_c, out_v, out_z);
      end else begin
        exp_m = sb_q.pop_front();
        n_cmp++;
        if (got_m !== exp_m) begin
          n_err++;
          $display("FAIL result: got res=%h c=%b v=%b z=%b, expected res=%h c=%b v=%b z=%b",
                   got_m.res, got_m.c, got_m.v, got_m.z, exp_m.res, exp_m.c, exp_m.v, exp_m.z);
        end
      end
    end
  end

  // Present a transaction and return once it has been accepted (1 time unit after the edge).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, output int acc_cyc);
    bit seen;
    seen = 1'b0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) begin
      in_valid = 1'b0;
      in_op = 2'($urandom);
      in_a  = 16'($urandom);
      in_b  = 16'($urandom);
    end
  endtask

  // Count edges from the accept until out_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: got out_valid=0, expected 1");
    end
  endtask

  vec_t tbl[11];
  int   ac, lat, prev_ac, h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b1, 1'b0}, 1};
    tbl[1]  = '{OP_SUB,  16'h0005, 16'h0005, '{16'h0000, 1'b1, 1'b0, 1'b1}, 1};
    tbl[2]  = '{OP_SUB,  16'h0000, 16'h0001, '{16'hFFFF, 1'b0, 1'b0, 1'b0}, 1};
    tbl[3]  = '{OP_SUB,  16'h8000, 16'h0001, '{16'h7FFF, 1'b1, 1'b1, 1'b0}, 1};
    tbl[4]  = '{OP_MUL,  16'h00FF, 16'h0101, '{16'hFFFF, 1'b0, 1'b0, 1'b0}, 16};
    tbl[5]  = '{OP_MUL,  16'h0100, 16'h0100, '{16'h0000, 1'b0, 1'b1, 1'b1}, 16};
    tbl[6]  = '{OP_MUL,  16'hFFFF, 16'h0001, '{16'hFFFF, 1'b0, 1'b0, 1'b0}, 16};
    tbl[7]  = '{OP_MUL,  16'h8000, 16'h0002, '{16'h0000, 1'b0, 1'b1, 1'b1}, 16};
    tbl[8]  = '{OP_PASS, 16'h0000, 16'hABCD, '{16'h0000, 1'b0, 1'b0, 1'b1}, 1};
    tbl[9]  = '{OP_PASS, 16'h1234, 16'hFFFF, '{16'h1234, 1'b0, 1'b0, 1'b0}, 1};
    tbl[10] = '{OP_ADD,  16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b1}, 1};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_outputs", {out_valid, out_result, out_c, out_v, out_z}, '0);

    // Table of single transactions with out_ready held high.
    foreach (tbl[k]) begin
      push(tbl[k].e);
      issue(tbl[k].op, tbl[k].a, tbl[k].b, 1'b0, ac);
      wait_valid(lat);
      check($sformatf("latency_%0d", k), lat, tbl[k].lat);
      @(posedge clk);
      #1;
      check($sformatf("released_%0d", k), {out_valid, in_ready}, 2'b01);
    end

    // Backpressure: result must hold while a second request waits.
    out_ready = 1'b0;
    h0 = n_handoff;
    push('{16'h0007, 1'b0, 1'b0, 1'b0});
    issue(OP_ADD, 16'h0003, 16'h0004, 1'b0, ac);
    wait_valid(lat);
    in_op = OP_ADD; in_a = 16'h0001; in_b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {out_valid, in_ready, out_result}, {1'b1, 1'b0, 16'h0007});
    end
    push('{16'h0002, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handoff", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    wait_valid(lat);
    check("bp_latency", lat, 1);
    @(posedge clk);
    #1;
    check("bp_handoffs", n_handoff - h0, 2);

    // Reset in the middle of a multiply drops it completely.
    issue(OP_MUL, 16'h1234, 16'h0003, 1'b0, ac);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midmul_reset", {out_valid, in_ready, out_result, out_c, out_v, out_z}, {1'b0, 1'b1, 19'd0});
    repeat (20) @(posedge clk);
    #1;
    check("midmul_dropped", out_valid, 0);
    push('{16'h1234, 1'b0, 1'b0, 1'b0});
    issue(OP_PASS, 16'h1234, 16'h5555, 1'b0, ac);
    wait_valid(lat);
    check("pass_latency", lat, 1);
    @(posedge clk);
    #1;

    // Back-to-back ADD stream: one accept every 3 cycles.
    prev_ac = 0;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      push(model(OP_ADD, ra, rb));
      issue(OP_ADD, ra, rb, 1'b1, ac);
      if (k > 0) check("stream_spacing", ac - prev_ac, 3);
      prev_ac = ac;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", sb_q.size(), 0);
    check("handoff_count", n_handoff, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Multi-cycle ALU controller that owns one full_adder instance and sequences it for ADD, SUB, PASS and unsigned shift-add MUL.
- Sits between the calculator's operand/opcode front end and its result/display path.
- Valid/ready handshake on input and output; one transaction in flight.

Parameters:
- DATA_WIDTH, 16, operand/result width; also the MUL iteration count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode valid.
- in_ready  output  1  block can accept a transaction.
- in_op  input  2  opcode: 0 ADD, 1 SUB, 2 MUL, 3 PASS.
- in_a  input  DATA_WIDTH  operand A.
- in_b  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  DATA_WIDTH  result.
- out_c  output  1  carry flag.
- out_v  output  1  overflow flag.
- out_z  output  1  zero flag (out_result == 0).

Behaviour:
- Reset (synchronous, active-high) forces state IDLE, out_valid=0, out_result=0, out_c=0, out_v=0, out_z=0, iteration counter=0. In-flight work is dropped, mid-MUL included.
- States: IDLE, EXEC, MUL, DONE.
- in_ready=1 only in IDLE, combinationally from state.
- Accept: in_valid && in_ready on an edge latches op, a and b. ADD/SUB/PASS go to EXEC; MUL goes to MUL.
- EXEC (one cycle): adder gets a and b' with carry_in cin.
  - ADD: b'=b, cin=0.
  - SUB: b'=~b, cin=1.
  - PASS: b'=0, cin=0.
- EXEC registers the following, then goes to DONE:
  - result = adder sum.
  - c = adder carry_out. For SUB, c=1 means no borrow.
  - v = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]). PASS forces c=0, v=0.
  - z = (result==0).
- ADD/SUB/PASS latency: out_valid rises after the first edge following the accept edge.
- MUL entry: acc=0, mcand=a, mplier=b, ovf=0, counter=0.
- MUL, each cycle, for exactly DATA_WIDTH cycles (no early exit):
  - Adder computes acc + mcand, cin=0.
  - If mplier[0]: acc <= sum; ovf |= carry_out.
  - If mcand[MSB] && (mplier>>1)!=0: ovf <= 1.
  - mcand <= mcand<<1; mplier <= mplier>>1; counter++.
- MUL exit: after the step with counter==DATA_WIDTH-1, register result=acc (low DATA_WIDTH bits), c=0, v=ovf, z=(result==0), then go to DONE.
- MUL latency: out_valid rises DATA_WIDTH edges after the accept edge.
- DONE: out_valid=1. out_result and flags stay stable until out_valid && out_ready on an edge, then the block returns to IDLE.
- Because in_ready=0 in DONE, no accept can coincide with result handoff. The next accept is possible at the earliest one cycle after handoff.
- in_a, in_b and in_op may change freely after the accept edge; only latched copies are used.
- Only one full_adder instance exists; its inputs are muxed by state. Its inputs are don't-care in IDLE and DONE.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [1:0] alu_op_t {OP_ADD, OP_SUB, OP_MUL, OP_PASS}.
  - typedef enum seq_state_t {S_IDLE, S_EXEC, S_MUL, S_DONE}.
  - localparam for counter width, $clog2(DATA_WIDTH).
- Sub-module: a single full_adder instance with DATA_WIDTH passed through. No other sub-modules.

Test Plan:
- ADD 0x7FFF + 0x0001, out_ready=1 -> out_result=0x8000, c=0, v=1, z=0; out_valid high exactly one cycle after the accept edge.
- SUB 0x0005 - 0x0005 -> 0x0000, c=1, v=0, z=1. SUB 0x0000 - 0x0001 -> 0xFFFF, c=0, v=0. SUB 0x8000 - 0x0001 -> 0x7FFF, v=1.
- MUL 0x00FF * 0x0101 -> 0xFFFF, c=0, v=0, latency 16.
  - MUL 0x0100 * 0x0100 -> 0x0000, v=1, z=1.
  - MUL 0xFFFF * 0x0001 -> 0xFFFF, v=0.
  - MUL 0x8000 * 0x0002 -> 0x0000, v=1.
- Backpressure: after ADD 3+4, hold out_ready=0 for 5 cycles with in_valid=1 (ADD 1+1) -> out_result=0x0007 stable, in_ready=0, second op not accepted.
  - Raise out_ready: 0x0007 handed off once, then 1+1 is accepted and yields 0x0002.
- Reset mid-MUL: assert rst for one cycle after MUL iteration 7 -> next cycle out_valid=0, in_ready=1, all outputs 0. A subsequent PASS 0x1234 -> 0x1234, c=0, v=0.
- PASS 0x0000 -> z=1. Back-to-back ADD streams with out_ready tied 1 -> one result every 3 cycles, none dropped or duplicated.
